// File: rtl/mul_div_unit_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITERS = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Magnitude of a two's-complement value when it is treated as signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
        mag = (is_signed && x[WIDTH-1]) ? WIDTH'(-x) : x;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
module mul_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl_rem;
    logic [WIDTH-1:0] sub_diff;

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps remainder:quotient and shifts left.
    always_comb begin
        add_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        shl_rem  = acc_i[2*WIDTH-1:WIDTH-1];
        sub_diff = shl_rem[WIDTH-1:0] - opnd_i;
        acc_o    = acc_i;
        if (is_div_i) begin
            if (shl_rem >= {1'b0, opnd_i}) begin
                acc_o = {sub_diff, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {shl_rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else if (acc_i[0]) begin
            acc_o = {add_sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and start/busy/done handshake.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = mul_div_unit_pkg::WIDTH,
    parameter int unsigned ITERS = mul_div_unit_pkg::ITERS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(ITERS);

    state_e             state_q;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_orig_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               b_zero_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_div;
    logic               op_signed;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    assign is_div    = op_q[1];
    assign op_signed = op[0];

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div),
        .acc_o    (acc_d)
    );

    // Sign correction and divide-by-zero override of the raw accumulator.
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? (2*WIDTH)'(-acc_q) : acc_q;
        quot_fix = (sign_a_q ^ sign_b_q) ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? WIDTH'(-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        hi_res   = prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero_q) begin
                hi_res = a_orig_q;
                lo_res = '1;
            end else begin
                hi_res = rem_fix;
                lo_res = quot_fix;
            end
        end
    end

    // Control FSM, iteration counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULTU;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        state_q  <= ST_RUN;
                        op_q     <= op_e'(op);
                        cnt_q    <= '0;
                        acc_q    <= {WIDTH'(0), mag(src_a, op_signed)};
                        opnd_q   <= mag(src_b, op_signed);
                        a_orig_q <= src_a;
                        sign_a_q <= op_signed & src_a[WIDTH-1];
                        sign_b_q <= op_signed & src_b[WIDTH-1];
                        b_zero_q <= (src_b == '0);
                        busy_q   <= 1'b1;
                    end else if (!start) begin
                        if (mthi) hi_q <= src_a;
                        if (mtlo) lo_q <= src_a;
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        if (cnt_q == CNT_W'(ITERS-1)) begin
                            state_q <= ST_FIX;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        hi_q   <= hi_res;
                        lo_q   <= lo_res;
                        done_q <= 1'b1;
                        dbz_q  <= is_div & b_zero_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    mul_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to completion (bounded).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_k, output int busy_n, output int done_n,
                          output logic dbz_at_done, output int dbz_bad);
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        done_k = -1; busy_n = 0; done_n = 0; dbz_at_done = 1'b0; dbz_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (busy) busy_n++;
            if (!done && div_by_zero) dbz_bad++;
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    dbz_at_done = div_by_zero;
                end
            end
            if (done_k >= 0 && k > done_k) break;
        end
    endtask

    initial begin
        int          dk;
        int          bn;
        int          dn;
        int          db;
        int          cnt;
        logic        dz;
        string       nm;

        checks = 0; failures = 0;
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'b10, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[6]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[11] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, dk, bn, dn, dz, db);
            nm = $sformatf("v%0d", i);
            chk({nm, "_latency"}, 32'(dk), 32'd33);
            chk({nm, "_busy_cycles"}, 32'(bn), 32'd33);
            chk({nm, "_done_pulses"}, 32'(dn), 32'd1);
            chk({nm, "_dbz"}, 32'(dz), 32'(vecs[i].dbz));
            chk({nm, "_dbz_outside_done"}, 32'(db), 32'd0);
            chk({nm, "_hi"}, hi, vecs[i].hi);
            chk({nm, "_lo"}, lo, vecs[i].lo);
        end

        // mthi then mtlo while idle
        @(negedge clk);
        mthi = 1'b1; src_a = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_done", 32'(done), 32'd0);
        mtlo = 1'b1; src_a = 32'hCAFE_0000;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFE_0000);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);
        chk("mtlo_done", 32'(done), 32'd0);

        // start with cancel in idle is suppressed
        start = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd2; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("idle_cancel_busy", 32'(busy), 32'd0);

        // DIVU 10/3 with ignored restart and cancel mid-run
        op = 2'b10; src_a = 32'd10; src_b = 32'd3; start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 5) begin
                start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5;
            end
            if (k == 6) begin
                start = 1'b0;
                chk("restart_ignored_busy", 32'(busy), 32'd1);
            end
            if (k == 20) cancel = 1'b1;
            if (k == 21) begin
                cancel = 1'b0;
                chk("cancel_busy", 32'(busy), 32'd0);
            end
            if (done) cnt++;
        end
        chk("cancel_no_done", 32'(cnt), 32'd0);
        chk("cancel_hi_kept", hi, 32'h1234_5678);
        chk("cancel_lo_kept", lo, 32'hCAFE_0000);

        // start together with mthi: start wins; mthi while busy ignored
        start = 1'b1; mthi = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'd7;
        dk = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; mthi = 1'b0;
                chk("start_mthi_busy", 32'(busy), 32'd1);
                chk("start_mthi_hi_kept", hi, 32'h1234_5678);
            end
            if (k == 3) begin
                mthi = 1'b1; mtlo = 1'b1; src_a = 32'hDEAD_BEEF;
            end
            if (k == 4) begin
                mthi = 1'b0; mtlo = 1'b0;
                chk("busy_mthi_hi_kept", hi, 32'h1234_5678);
                chk("busy_mtlo_lo_kept", lo, 32'hCAFE_0000);
            end
            if (done && dk < 0) dk = k;
            if (dk >= 0) break;
        end
        chk("start_mthi_latency", 32'(dk), 32'd33);
        chk("start_mthi_hi", hi, 32'd0);
        chk("start_mthi_lo", lo, 32'd42);

        // asynchronous reset in the middle of a MULT
        @(negedge clk);
        op = 2'b01; src_a = 32'hFFFF_FFF9; src_b = 32'd3; start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_dbz", 32'(div_by_zero), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("arst_no_done", 32'(cnt), 32'd0);

        // cancel arriving in the completion cycle wins
        op = 2'b10; src_a = 32'd10; src_b = 32'd3; start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 32) cancel = 1'b1;
            if (k == 33) begin
                cancel = 1'b0;
                chk("fix_cancel_busy", 32'(busy), 32'd0);
            end
            if (done) cnt++;
        end
        chk("fix_cancel_no_done", 32'(cnt), 32'd0);
        chk("fix_cancel_hi", hi, 32'd0);
        chk("fix_cancel_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
